// File: rtl/pps_holdover_receiver.sv
// ---------------------------------------------------------------------------
// pps_holdover_receiver
//
// Purpose
//   Receives an external 1PPS reference and regenerates a clean 1PPS for the
//   fabric timebase / timestamping logic. The receiver:
//     - synchronises pps_in and turns its rising edge into a 1-cycle strobe,
//     - measures every edge-to-edge interval in clk cycles,
//     - qualifies each interval against F +/- T and locks after
//       C_LOCK_COUNT consecutive good intervals,
//     - runs a flywheel phase counter that drives pps_out and keeps it
//       going for C_HOLDOVER_SECONDS seconds if the reference disappears.
//
// Build option
//   PPS_RECEIVER_DEGLITCH_EN : when defined, the synchronised input must stay
//   high for C_DEGLITCH consecutive cycles before an edge strobe is issued.
//   Shorter pulses are ignored and the edge latency grows by C_DEGLITCH-1.
//   When undefined the plain synchronised rising edge is used and
//   C_DEGLITCH has no effect.
//
// Ports
//   clk           in   1   core clock
//   rst           in   1   asynchronous, active-high reset
//   pps_in        in   1   external 1PPS, asynchronous to clk
//   pps_out       out  1   regenerated 1PPS (registered)
//   pps_locked    out  1   state == LOCKED
//   pps_holdover  out  1   state == HOLDOVER
//   pps_error     out  1   1-cycle pulse on an invalid or missing edge
//   pps_period    out  32  interval (clk cycles) ending at the latest edge
//   pps_state     out  2   debug view of the FSM state
//                          (0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER)
// ---------------------------------------------------------------------------
module pps_holdover_receiver #(
    parameter int unsigned C_CLOCK_FREQUENCY  = 125000000,
    parameter int unsigned C_PPS_DELAY        = 12500,
    parameter int unsigned C_PULSE_WIDTH      = 12500000,
    parameter int unsigned C_TOLERANCE        = 1250,
    parameter int unsigned C_LOCK_COUNT       = 3,
    parameter int unsigned C_HOLDOVER_SECONDS = 10,
    parameter int unsigned C_SYNC_STAGES      = 3,
    parameter int unsigned C_DEGLITCH         = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_in,
    output logic        pps_out,
    output logic        pps_locked,
    output logic        pps_holdover,
    output logic        pps_error,
    output logic [31:0] pps_period,
    output logic [1:0]  pps_state
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    localparam int unsigned PH_W = (C_CLOCK_FREQUENCY > 1) ? $clog2(C_CLOCK_FREQUENCY) : 1;

    localparam logic [31:0]     N_MIN   = 32'(C_CLOCK_FREQUENCY - C_TOLERANCE);
    localparam logic [31:0]     N_MAX   = 32'(C_CLOCK_FREQUENCY + C_TOLERANCE);
    localparam logic [31:0]     CNT_SAT = 32'hFFFF_FFFF;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(C_CLOCK_FREQUENCY - 1);
    localparam logic [PH_W-1:0] PH_ON   = PH_W'(C_PPS_DELAY);
    localparam logic [PH_W-1:0] PH_OFF  = PH_W'(C_PPS_DELAY + C_PULSE_WIDTH - 1);
    localparam logic [3:0]      LOCK_N  = 4'(C_LOCK_COUNT);
    localparam logic [7:0]      HOLD_N  = 8'(C_HOLDOVER_SECONDS);

    // -----------------------------------------------------------------------
    // Input synchroniser
    // -----------------------------------------------------------------------
    logic [C_SYNC_STAGES-1:0] sync_q;
    logic                     pps_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[C_SYNC_STAGES-2:0], pps_in};
        end
    end

    assign pps_s = sync_q[C_SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Edge qualifier
    // high_cnt counts consecutive high cycles of pps_s seen before the
    // current cycle (saturating at DG_CYCLES). The strobe fires in the cycle
    // pps_s has been high for exactly DG_CYCLES cycles, so it fires once per
    // pulse. With DG_CYCLES = 1 this is a plain rising-edge detector.
    // -----------------------------------------------------------------------
`ifdef PPS_RECEIVER_DEGLITCH_EN
    localparam int unsigned DG_CYCLES = (C_DEGLITCH < 1) ? 1 : C_DEGLITCH;
`else
    // Threshold of one cycle: raw rising edge. C_DEGLITCH intentionally has
    // no influence on the result in this build.
    localparam int unsigned DG_CYCLES = 1 + (C_DEGLITCH * 0);
`endif

    localparam int unsigned    DG_W    = $clog2(DG_CYCLES + 1);
    localparam logic [DG_W-1:0] DG_FIRE = DG_W'(DG_CYCLES - 1);
    localparam logic [DG_W-1:0] DG_SAT  = DG_W'(DG_CYCLES);

    logic [DG_W-1:0] high_cnt;
    logic            edge_stb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_cnt <= '0;
        end else if (!pps_s) begin
            high_cnt <= '0;
        end else if (high_cnt != DG_SAT) begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

    assign edge_stb = pps_s && (high_cnt == DG_FIRE);

    // -----------------------------------------------------------------------
    // Interval measurement / flywheel helpers
    // -----------------------------------------------------------------------
    state_t          state;
    logic [31:0]     cnt;
    logic [PH_W-1:0] ph;
    logic [3:0]      good;
    logic [7:0]      hold;

    logic [31:0] n_meas;     // interval ending in this cycle (cnt+1, saturating)
    logic        n_valid;
    logic        ph_wrap;
    logic        timeout;
    logic        in_window;

    always_comb begin
        n_meas    = (cnt == CNT_SAT) ? cnt : cnt + 32'd1;
        n_valid   = (n_meas >= N_MIN) && (n_meas <= N_MAX);
        ph_wrap   = (ph == PH_LAST);
        // >= rather than == : in LOCKED a late edge arriving exactly at
        // cnt == F+T is rejected without clearing cnt, so cnt moves past F+T
        // and the missing reference must still be detected one cycle later.
        timeout   = (cnt >= N_MAX);
        in_window = (ph >= PH_ON) && (ph <= PH_OFF);
    end

    // -----------------------------------------------------------------------
    // Main FSM with counters and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_UNLOCKED;
            cnt        <= '0;
            ph         <= '0;
            good       <= '0;
            hold       <= '0;
            pps_out    <= 1'b0;
            pps_error  <= 1'b0;
            pps_period <= '0;
        end else begin
            pps_error <= 1'b0;
            cnt       <= n_meas;
            ph        <= ph_wrap ? '0 : ph + 1'b1;
            pps_out   <= in_window && ((state == ST_LOCKED) || (state == ST_HOLDOVER));

            if (edge_stb) begin
                pps_period <= n_meas;
            end

            case (state)
                ST_UNLOCKED: begin
                    if (edge_stb) begin
                        state <= ST_ACQUIRE;
                        good  <= '0;
                        cnt   <= '0;
                    end
                end

                ST_ACQUIRE: begin
                    if (edge_stb) begin
                        cnt <= '0;
                        if (n_valid) begin
                            ph <= '0;
                            if (good + 4'd1 == LOCK_N) begin
                                state <= ST_LOCKED;
                                good  <= '0;
                            end else begin
                                good <= good + 4'd1;
                            end
                        end else begin
                            good      <= '0;
                            pps_error <= 1'b1;
                        end
                    end else if (timeout) begin
                        state     <= ST_UNLOCKED;
                        good      <= '0;
                        pps_error <= 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (edge_stb) begin
                        if (n_valid) begin
                            // Realign; coincides with a natural wrap when the
                            // reference is on time, so no extra pulse.
                            cnt <= '0;
                            ph  <= '0;
                        end else begin
                            // Rejected edge: timebase keeps running untouched.
                            pps_error <= 1'b1;
                        end
                    end else if (timeout) begin
                        state     <= ST_HOLDOVER;
                        hold      <= '0;
                        pps_error <= 1'b1;
                    end
                end

                ST_HOLDOVER: begin
                    if (edge_stb) begin
                        state <= ST_ACQUIRE;
                        good  <= '0;
                        cnt   <= '0;
                    end else if (ph_wrap) begin
                        if (hold + 8'd1 == HOLD_N) begin
                            state <= ST_UNLOCKED;
                            hold  <= '0;
                        end else begin
                            hold <= hold + 8'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_UNLOCKED;
                end
            endcase
        end
    end

    // Status flags are direct decodes of the state register.
    assign pps_locked   = (state == ST_LOCKED);
    assign pps_holdover = (state == ST_HOLDOVER);
    assign pps_state    = state;

endmodule

// File: tb/tb_pps_holdover_receiver.sv
// ---------------------------------------------------------------------------
// tb_pps_holdover_receiver
// Directed bench for pps_holdover_receiver with F=1000, T=10, D=100, W=200,
// LOCK=3, HOLD=2, SYNC=3. All timing is tracked in clk cycles (cyc); a pps_in
// rise driven just after the posedge numbered d is first sampled at d+1.
// ---------------------------------------------------------------------------
module tb_pps_holdover_receiver;

    localparam int F = 1000;
`ifdef PPS_RECEIVER_DEGLITCH_EN
    localparam int DG_EXTRA = 3;
`else
    localparam int DG_EXTRA = 0;
`endif
    localparam int E0  = 4 + DG_EXTRA;     // drive -> cnt/ph cleared
    localparam int LAT = 105 + DG_EXTRA;   // drive -> pps_out rise
    localparam int TMO = E0 + 1011;        // drive -> missing-edge error

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        pps_in;
    logic        pps_out, pps_locked, pps_holdover, pps_error;
    logic [31:0] pps_period;
    logic [1:0]  pps_state;

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pps_holdover_receiver #(
        .C_CLOCK_FREQUENCY (1000),
        .C_PPS_DELAY       (100),
        .C_PULSE_WIDTH     (200),
        .C_TOLERANCE       (10),
        .C_LOCK_COUNT      (3),
        .C_HOLDOVER_SECONDS(2),
        .C_SYNC_STAGES     (3),
        .C_DEGLITCH        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pps_in      (pps_in),
        .pps_out     (pps_out),
        .pps_locked  (pps_locked),
        .pps_holdover(pps_holdover),
        .pps_error   (pps_error),
        .pps_period  (pps_period),
        .pps_state   (pps_state)
    );

    // ---------------- output monitor ----------------
    int   rise_cnt = 0, last_rise = -1, last_fall = -1;
    int   err_cycles = 0, last_err = -1;
    logic out_d = 1'b0;

    always @(negedge clk) begin
        if (pps_out && !out_d) begin rise_cnt++; last_rise = cyc; end
        if (!pps_out && out_d) last_fall = cyc;
        if (pps_error) begin err_cycles++; last_err = cyc; end
        out_d = pps_out;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    int drv = 0;   // cycle of the most recent pps_in rise

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rise_at(input int c, input int hi);
        wait_until(c);
        pps_in = 1'b1;
        drv    = cyc;
        wait_until(drv + hi);
        pps_in = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int a, b, L, h, g, rc, eb;

    initial begin
        rst    = 1'b1;
        pps_in = 1'b0;
        wait_until(5);
        check("rst_pps_out", pps_out, 0);
        check("rst_locked", pps_locked, 0);
        check("rst_holdover", pps_holdover, 0);
        check("rst_error", pps_error, 0);
        check("rst_period", pps_period, 0);
        check("rst_state", pps_state, 0);
        rst = 1'b0;

        // --- lock on the 4th edge of a 1000-cycle reference ---
        rise_at(20, 100);
        rise_at(drv + F, 100);
        rise_at(drv + F, 100);
        check("acq_state_3rd", pps_state, 1);
        check("acq_unlocked_3rd", pps_locked, 0);
        rise_at(drv + F, 100);
        check("lock_4th", pps_locked, 1);
        check("lock_period", pps_period, 1000);
        check("lock_no_err", err_cycles, 0);
        wait_until(drv + 400);
        check("lock_latency", last_rise - drv, LAT);
        check("lock_width", last_fall - last_rise, 200);
        rise_at(drv + F, 100);
        wait_until(drv + 400);
        check("steady_latency", last_rise - drv, LAT);
        check("steady_width", last_fall - last_rise, 200);
        check("steady_period", pps_period, 1000);

        // --- tolerance edges in LOCKED ---
        rise_at(drv + 990, 100);
        wait_until(drv + 200);
        check("tol_990_period", pps_period, 990);
        check("tol_990_no_err", err_cycles, 0);
        rise_at(drv + 1010, 100);
        a = drv;
        wait_until(a + 400);
        check("tol_1010_period", pps_period, 1010);
        check("tol_1010_latency", last_rise - a, LAT);
        check("tol_1010_no_err", err_cycles, 0);

        // --- early (989) edge in LOCKED is rejected, timebase untouched ---
        rise_at(a + 989, 5);
        wait_until(a + 998);
        check("early_err", err_cycles, 1);
        check("early_period", pps_period, 989);
        check("early_locked", pps_locked, 1);
        rc = rise_cnt;
        rise_at(a + 1000, 100);
        check("early_no_shift", rise_cnt, rc);
        wait_until(a + 1300);
        check("early_phase", last_rise - a, 1000 + LAT);
        check("early_next_period", pps_period, 1000);

        // --- reset in the middle of a pulse while LOCKED ---
        wait_until(drv + 200);
        check("pre_rst_high", pps_out, 1);
        rst = 1'b1;
        #1;
        check("midrst_pps_out", pps_out, 0);
        check("midrst_locked", pps_locked, 0);
        check("midrst_period", pps_period, 0);
        wait_until(cyc + 3);
        rst = 1'b0;
        rc = rise_cnt;
        wait_until(cyc + 1200);
        check("postrst_no_pulse", rise_cnt, rc);
        check("postrst_state", pps_state, 0);

        // --- ACQUIRE timeout, then no error while UNLOCKED ---
        eb = err_cycles;
        rise_at(cyc + 10, 100);
        check("acq_enter", pps_state, 1);
        wait_until(drv + TMO + 2);
        check("acq_tmo_err", err_cycles, eb + 1);
        check("acq_tmo_when", last_err - drv, TMO);
        check("acq_tmo_state", pps_state, 0);
        wait_until(drv + 2500);
        check("unlocked_no_err", err_cycles, eb + 1);

        // --- 989 in ACQUIRE resets good count ---
        rise_at(drv + 3000, 100);
        b = drv;
        rise_at(b + 989, 100);
        check("acq_989_err", err_cycles, eb + 2);
        check("acq_989_state", pps_state, 1);
        rise_at(drv + F, 100);
        rise_at(drv + F, 100);
        check("acq_relock_2", pps_locked, 0);
        rise_at(drv + F, 100);
        check("acq_relock_3", pps_locked, 1);

        // --- reference lost: holdover, flywheel, then unlock ---
        L  = drv;
        eb = err_cycles;
        wait_until(L + TMO + 1);
        check("ho_enter", pps_holdover, 1);
        check("ho_err_when", last_err - L, TMO);
        check("ho_err_1cyc", err_cycles, eb + 1);
        rc = rise_cnt;
        wait_until(L + E0 + 3005);
        check("ho_pulses", rise_cnt, rc + 2);
        check("ho_last_rise", last_rise - L, LAT + 2000);
        check("ho_exit_holdover", pps_holdover, 0);
        check("ho_exit_locked", pps_locked, 0);
        wait_until(L + 3500);
        check("ho_out_stays_low", rise_cnt, rc + 2);

        // --- relock, enter holdover, resume mid-pulse ---
        rise_at(cyc + 10, 100);
        rise_at(drv + F, 100);
        rise_at(drv + F, 100);
        rise_at(drv + F, 100);
        L  = drv;
        eb = err_cycles;
        wait_until(L + LAT + 1050);
        check("resume_pre_holdover", pps_holdover, 1);
        check("resume_pre_high", pps_out, 1);
        rise_at(L + LAT + 1050, 100);
        h = drv;
        check("resume_acquire", pps_state, 1);
        check("resume_out_off", pps_out, 0);
        check("resume_fall_when", last_fall - h, E0 + 1);
        rise_at(h + F, 100);
        rise_at(drv + F, 100);
        check("resume_not_yet", pps_locked, 0);
        rise_at(drv + F, 100);
        check("resume_locked", pps_locked, 1);
        check("resume_errs", err_cycles, eb + 1);

        // --- 2-cycle glitch 500 cycles after an accepted edge ---
        g  = drv;
        eb = err_cycles;
        rise_at(g + 500, 2);
        wait_until(g + 520);
`ifdef PPS_RECEIVER_DEGLITCH_EN
        check("glitch_ignored", err_cycles, eb);
        check("glitch_period", pps_period, 1000);
`else
        check("glitch_err", err_cycles, eb + 1);
        check("glitch_period", pps_period, 500);
`endif
        check("glitch_locked", pps_locked, 1);
        rise_at(g + F, 100);
        wait_until(drv + 400);
        check("post_glitch_period", pps_period, 1000);
        check("post_glitch_latency", last_rise - drv, LAT);
        check("post_glitch_locked", pps_locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
